// File: rtl/fetch_req_tracker.sv
// Tracks outstanding I$ fetch requests in a small FIFO and drops responses
// whose request was in flight when the frontend was killed.
module fetch_req_tracker #(
    parameter int unsigned VLEN   = 39,
    parameter int unsigned DEPTH  = 4,
    parameter bit          REG_IN = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     mispredict_i,
    input  logic                     replay_i,
    input  logic                     bp_valid_i,
    input  logic                     speculative_i,
    input  logic                     iq_ready_i,
    input  logic [VLEN-1:0]          next_addr_i,
    output logic                     icache_req_o,
    input  logic                     icache_ready_i,
    output logic [VLEN-1:0]          icache_vaddr_o,
    output logic                     icache_spec_o,
    output logic                     icache_kill_s1_o,
    output logic                     icache_kill_s2_o,
    input  logic                     icache_rvalid_i,
    output logic                     fetch_valid_o,
    output logic [VLEN-1:0]          fetch_vaddr_o,
    output logic [$clog2(DEPTH):0]   outstanding_o,
    output logic                     err_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = VLEN + 6;

    logic [SW-1:0]   stage_d;
    logic [SW-1:0]   stage_s;
    logic            s_flush, s_mispredict, s_replay, s_bp_valid, s_speculative, s_iq_ready;
    logic [VLEN-1:0] s_next_addr;

    always_comb begin
        stage_d = {flush_i, mispredict_i, replay_i, bp_valid_i,
                   speculative_i, iq_ready_i, next_addr_i};
    end

    generate
        if (REG_IN) begin : g_reg_in
            logic [SW-1:0] stage_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) stage_q <= '0;
                else         stage_q <= stage_d;
            end
            assign stage_s = stage_q;
        end else begin : g_comb_in
            assign stage_s = stage_d;
        end
    endgenerate

    assign {s_flush, s_mispredict, s_replay, s_bp_valid,
            s_speculative, s_iq_ready, s_next_addr} = stage_s;

    logic [VLEN-1:0]  addr_q [DEPTH];
    logic [VLEN-1:0]  addr_d [DEPTH];
    logic [DEPTH-1:0] discard_q, discard_d;
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic             kill, push, pop, not_empty, not_full;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign kill      = s_flush | s_mispredict | s_replay;
    assign not_empty = (count_q != '0);
    assign not_full  = (count_q < CW'(DEPTH));

    assign icache_kill_s1_o = kill;
    assign icache_kill_s2_o = kill | s_bp_valid;
    assign icache_req_o     = s_iq_ready & ~kill & not_full;
    assign icache_vaddr_o   = s_next_addr;
    assign icache_spec_o    = s_speculative;

    assign push = icache_req_o & icache_ready_i;
    assign pop  = icache_rvalid_i & not_empty;

    // A response is forwarded only if its request survived every kill so far
    // and the current stage is not itself killing stage 2.
    assign fetch_valid_o = pop & ~discard_q[rptr_q] & ~icache_kill_s2_o;
    assign fetch_vaddr_o = not_empty ? addr_q[rptr_q] : '0;
    assign outstanding_o = count_q;
    assign err_o         = err_q;

    always_comb begin
        addr_d    = addr_q;
        discard_d = kill ? '1 : discard_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        err_d     = err_q | (icache_rvalid_i & ~not_empty);
        if (push) begin
            addr_d[wptr_q]    = s_next_addr;
            discard_d[wptr_q] = 1'b0;
            wptr_d            = wrap_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = wrap_inc(rptr_q);
        end
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
            discard_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            discard_q <= discard_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_fetch_req_tracker.sv
// Drives a DEPTH=4 and a DEPTH=2 tracker with shared stimulus and checks both
// against a queue-based reference model.
module tb_fetch_req_tracker;

    localparam int VLEN = 39;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i, mispredict_i, replay_i, bp_valid_i, speculative_i, iq_ready_i;
    logic [VLEN-1:0] next_addr_i;
    logic            icache_ready_i, icache_rvalid_i;

    logic            o_req [2];
    logic            o_spec [2];
    logic            o_k1 [2];
    logic            o_k2 [2];
    logic            o_fv [2];
    logic            o_err [2];
    logic [VLEN-1:0] o_va [2];
    logic [VLEN-1:0] o_fva [2];
    logic [2:0]      o_out0;
    logic [1:0]      o_out1;

    always #5 clk_i = ~clk_i;

    fetch_req_tracker #(.VLEN(VLEN), .DEPTH(4), .REG_IN(1'b1)) u_dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .mispredict_i(mispredict_i),
        .replay_i(replay_i), .bp_valid_i(bp_valid_i), .speculative_i(speculative_i),
        .iq_ready_i(iq_ready_i), .next_addr_i(next_addr_i), .icache_req_o(o_req[0]),
        .icache_ready_i(icache_ready_i), .icache_vaddr_o(o_va[0]), .icache_spec_o(o_spec[0]),
        .icache_kill_s1_o(o_k1[0]), .icache_kill_s2_o(o_k2[0]), .icache_rvalid_i(icache_rvalid_i),
        .fetch_valid_o(o_fv[0]), .fetch_vaddr_o(o_fva[0]), .outstanding_o(o_out0), .err_o(o_err[0])
    );

    fetch_req_tracker #(.VLEN(VLEN), .DEPTH(2), .REG_IN(1'b1)) u_dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .mispredict_i(mispredict_i),
        .replay_i(replay_i), .bp_valid_i(bp_valid_i), .speculative_i(speculative_i),
        .iq_ready_i(iq_ready_i), .next_addr_i(next_addr_i), .icache_req_o(o_req[1]),
        .icache_ready_i(icache_ready_i), .icache_vaddr_o(o_va[1]), .icache_spec_o(o_spec[1]),
        .icache_kill_s1_o(o_k1[1]), .icache_kill_s2_o(o_k2[1]), .icache_rvalid_i(icache_rvalid_i),
        .fetch_valid_o(o_fv[1]), .fetch_vaddr_o(o_fva[1]), .outstanding_o(o_out1), .err_o(o_err[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one queue of in-flight requests per DUT, plus the
    // previous cycle's inputs as the registered stage.
    typedef struct packed {
        logic [VLEN-1:0] addr;
        logic            disc;
    } ent_t;

    ent_t            mq [2][$];
    int              dep [2];
    bit              merr [2];
    bit              ms_fl, ms_mp, ms_rp, ms_bp, ms_sp, ms_iq;
    logic [VLEN-1:0] ms_addr;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            merr[d] = 1'b0;
        end
        {ms_fl, ms_mp, ms_rp, ms_bp, ms_sp, ms_iq} = '0;
        ms_addr = '0;
    endtask

    task automatic model_step(input int d);
        int              n;
        bit              kill, k2, req, fv;
        logic [VLEN-1:0] fa;
        logic [63:0]     outs;
        ent_t            e;
        n    = mq[d].size();
        kill = ms_fl | ms_mp | ms_rp;
        k2   = kill | ms_bp;
        req  = ms_iq && !kill && (n < dep[d]);
        fv   = icache_rvalid_i && (n > 0) && !mq[d][0].disc && !k2;
        fa   = (n > 0) ? mq[d][0].addr : '0;
        outs = (d == 0) ? 64'(o_out0) : 64'(o_out1);
        check($sformatf("dut%0d_req", d),   64'(o_req[d]),  64'(req));
        check($sformatf("dut%0d_vaddr", d), 64'(o_va[d]),   64'(ms_addr));
        check($sformatf("dut%0d_spec", d),  64'(o_spec[d]), 64'(ms_sp));
        check($sformatf("dut%0d_kill1", d), 64'(o_k1[d]),   64'(kill));
        check($sformatf("dut%0d_kill2", d), 64'(o_k2[d]),   64'(k2));
        check($sformatf("dut%0d_fvalid", d), 64'(o_fv[d]),  64'(fv));
        check($sformatf("dut%0d_fvaddr", d), 64'(o_fva[d]), 64'(fa));
        check($sformatf("dut%0d_count", d), outs,           64'(n));
        check($sformatf("dut%0d_err", d),   64'(o_err[d]),  64'(merr[d]));
        if (kill) begin
            for (int i = 0; i < n; i++) begin
                e = mq[d][i];
                e.disc = 1'b1;
                mq[d][i] = e;
            end
        end
        if (icache_rvalid_i && n > 0) void'(mq[d].pop_front());
        if (icache_rvalid_i && n == 0) merr[d] = 1'b1;
        if (req && icache_ready_i) begin
            e.addr = ms_addr;
            e.disc = 1'b0;
            mq[d].push_back(e);
        end
    endtask

    task automatic tick();
        #1;
        model_step(0);
        model_step(1);
        {ms_fl, ms_mp, ms_rp, ms_bp, ms_sp, ms_iq} =
            {flush_i, mispredict_i, replay_i, bp_valid_i, speculative_i, iq_ready_i};
        ms_addr = next_addr_i;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle();
        {flush_i, mispredict_i, replay_i, bp_valid_i, speculative_i, iq_ready_i} = '0;
        next_addr_i     = '0;
        icache_ready_i  = 1'b0;
        icache_rvalid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst%0d_req", d),   64'(o_req[d]), 64'd0);
            check($sformatf("rst%0d_kill1", d), 64'(o_k1[d]),  64'd0);
            check($sformatf("rst%0d_kill2", d), 64'(o_k2[d]),  64'd0);
            check($sformatf("rst%0d_vaddr", d), 64'(o_va[d]),  64'd0);
            check($sformatf("rst%0d_fvalid", d), 64'(o_fv[d]), 64'd0);
            check($sformatf("rst%0d_fvaddr", d), 64'(o_fva[d]), 64'd0);
            check($sformatf("rst%0d_err", d),   64'(o_err[d]), 64'd0);
        end
        check("rst0_count", 64'(o_out0), 64'd0);
        check("rst1_count", 64'(o_out1), 64'd0);
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic drain();
        iq_ready_i      = 1'b0;
        icache_rvalid_i = 1'b1;
        for (int k = 0; k < 20 && mq[0].size() > 0; k++) tick();
        icache_rvalid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        logic [63:0] r;
        dep[0] = 4;
        dep[1] = 2;
        rst_ni = 1'b0;
        idle();
        model_reset();
        @(negedge clk_i);
        do_reset();

        // Single request and response
        iq_ready_i = 1'b1; next_addr_i = VLEN'('h1000); icache_ready_i = 1'b1;
        tick();
        iq_ready_i = 1'b0;
        #1;
        check("single_req", 64'(o_req[0]), 64'd1);
        check("single_vaddr", 64'(o_va[0]), 64'h1000);
        tick();
        icache_rvalid_i = 1'b1;
        #1;
        check("single_fvalid", 64'(o_fv[0]), 64'd1);
        check("single_fvaddr", 64'(o_fva[0]), 64'h1000);
        tick();
        icache_rvalid_i = 1'b0;
        #1;
        check("single_count", 64'(o_out0), 64'd0);
        tick();

        // Fill to capacity, then free one slot
        iq_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_addr_i = VLEN'('h1100 + i * 4);
            tick();
        end
        #1;
        check("full_count", 64'(o_out0), 64'd4);
        check("full_req", 64'(o_req[0]), 64'd0);
        icache_rvalid_i = 1'b1;
        tick();
        icache_rvalid_i = 1'b0;
        #1;
        check("unfull_count", 64'(o_out0), 64'd3);
        check("unfull_req", 64'(o_req[0]), 64'd1);
        tick();
        drain();

        // Flush with three outstanding
        iq_ready_i = 1'b1; icache_ready_i = 1'b1; next_addr_i = VLEN'('h1800);
        for (int k = 0; k < 20 && mq[0].size() < 3; k++) tick();
        iq_ready_i = 1'b0; icache_ready_i = 1'b0;
        tick();
        #1;
        check("kill_pre_count", 64'(o_out0), 64'd3);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; iq_ready_i = 1'b1; icache_ready_i = 1'b1; next_addr_i = VLEN'('h2000);
        #1;
        check("kill_s1", 64'(o_k1[0]), 64'd1);
        check("kill_s2", 64'(o_k2[0]), 64'd1);
        check("kill_nopush", 64'(o_req[0]), 64'd0);
        tick();
        iq_ready_i = 1'b0;
        #1;
        check("kill_s1_clear", 64'(o_k1[0]), 64'd0);
        tick();
        icache_rvalid_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            if (j < 3) begin
                check("kill_dropped", 64'(o_fv[0]), 64'd0);
            end else begin
                check("kill_live_fvalid", 64'(o_fv[0]), 64'd1);
                check("kill_live_fvaddr", 64'(o_fva[0]), 64'h2000);
            end
            tick();
        end
        icache_rvalid_i = 1'b0;

        // Predicted-taken branch kills only stage 2
        iq_ready_i = 1'b1; next_addr_i = VLEN'('h4000);
        tick();
        iq_ready_i = 1'b0;
        tick();
        bp_valid_i = 1'b1;
        tick();
        bp_valid_i = 1'b0; icache_rvalid_i = 1'b1;
        #1;
        check("bp_kill2", 64'(o_k2[0]), 64'd1);
        check("bp_kill1", 64'(o_k1[0]), 64'd0);
        check("bp_fvalid", 64'(o_fv[0]), 64'd0);
        tick();
        icache_rvalid_i = 1'b0;
        #1;
        check("bp_popped", 64'(o_out0), 64'd0);
        tick();

        // Back-to-back push and pop, exercising pointer wrap
        iq_ready_i = 1'b1; icache_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            next_addr_i     = VLEN'('h3000 + i * 4);
            icache_rvalid_i = (i >= 2);
            #1;
            if (i >= 2) begin
                check("b2b_count2", 64'(o_out1), 64'd1);
                check("b2b_count4", 64'(o_out0), 64'd1);
            end
            tick();
        end
        drain();

        // Response with nothing outstanding is sticky
        #1;
        check("err_clean", 64'(o_err[0]), 64'd0);
        icache_rvalid_i = 1'b1;
        tick();
        icache_rvalid_i = 1'b0;
        #1;
        check("err_set", 64'(o_err[0]), 64'd1);
        tick();
        tick();
        #1;
        check("err_held", 64'(o_err[0]), 64'd1);

        // Reset in the middle of traffic
        iq_ready_i = 1'b1; icache_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_addr_i = VLEN'('h5000 + i * 4);
            tick();
        end
        do_reset();
        iq_ready_i = 1'b0; icache_ready_i = 1'b0; icache_rvalid_i = 1'b1;
        tick();
        icache_rvalid_i = 1'b0;
        #1;
        check("err_after_rst", 64'(o_err[0]), 64'd1);
        tick();

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            flush_i         = ($urandom_range(15) == 0);
            mispredict_i    = ($urandom_range(15) == 0);
            replay_i        = ($urandom_range(15) == 0);
            bp_valid_i      = ($urandom_range(7) == 0);
            speculative_i   = $urandom_range(1) == 1;
            iq_ready_i      = ($urandom_range(3) != 0);
            icache_ready_i  = ($urandom_range(3) != 0);
            icache_rvalid_i = ($urandom_range(1) == 1);
            r = {$urandom(), $urandom()};
            next_addr_i = r[VLEN-1:0];
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_req_tracker.md
FETCH_REQ_TRACKER -- requirements
Module: fetch_req_tracker

Interface
REQ-001 SHALL have parameter VLEN, default 39, virtual fetch address width.
REQ-002 SHALL have parameter DEPTH, default 4, max outstanding I$ requests; legal values 2, 4, 8.
REQ-003 SHALL have parameter REG_IN, default 1; 1 = control/address inputs registered one cycle, 0 = used combinationally.
REQ-004 SHALL have ports (clock and reset first):
- clk_i  in  1  clock; reset rst_ni, asynchronous, active-low
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  frontend flush
- mispredict_i  in  1  resolved branch valid and mispredicted
- replay_i  in  1  instruction queue replay request
- bp_valid_i  in  1  branch predicted taken in current fetch
- speculative_i  in  1  fetch is speculative
- iq_ready_i  in  1  instruction queue can accept
- next_addr_i  in  VLEN  next fetch PC
- icache_req_o  out  1  request valid to I$
- icache_ready_i  in  1  I$ accepts request
- icache_vaddr_o  out  VLEN  request address
- icache_spec_o  out  1  request is speculative
- icache_kill_s1_o  out  1  kill I$ stage 1
- icache_kill_s2_o  out  1  kill I$ stage 2
- icache_rvalid_i  in  1  I$ returns data for oldest outstanding request
- fetch_valid_o  out  1  returned data is live, forward to fetch
- fetch_vaddr_o  out  VLEN  address of returned data
- outstanding_o  out  clog2(DEPTH)+1  outstanding request count
- err_o  out  1  sticky: response received with no outstanding request

Function
REQ-005 SHALL form stage signals s_* = inputs registered (REG_IN=1) or raw inputs (REG_IN=0), for flush, mispredict, replay, bp_valid, speculative, iq_ready, next_addr.
REQ-006 SHALL define kill = s_flush | s_mispredict | s_replay.
REQ-007 SHALL drive icache_kill_s1_o = kill and icache_kill_s2_o = kill | s_bp_valid.
REQ-008 SHALL drive icache_req_o = s_iq_ready & !kill & (count < DEPTH).
REQ-009 SHALL drive icache_vaddr_o = s_next_addr and icache_spec_o = s_speculative.
REQ-010 SHALL push {icache_vaddr_o, icache_spec_o, discard=0} into a DEPTH-entry tracker FIFO when icache_req_o & icache_ready_i.
REQ-011 SHALL pop the head entry when icache_rvalid_i and count > 0.
REQ-012 SHALL assert fetch_valid_o combinationally in the pop cycle iff the head discard bit is 0 and icache_kill_s2_o is 0; fetch_vaddr_o = head address whenever count > 0, else 0.
REQ-013 SHALL, in any cycle with kill = 1, set the discard bit of every occupied entry (including an entry popped that cycle, which is dropped).
REQ-014 SHALL, on simultaneous push and pop, leave count unchanged; the pushed entry is written with discard=0.
REQ-015 SHALL wrap read/write pointers from DEPTH-1 to 0; count ranges 0..DEPTH and never over/underflows.
REQ-016 SHALL hold icache_req_o low while count = DEPTH; no push possible when full.
REQ-017 SHALL ignore icache_rvalid_i when count = 0 (no pop, fetch_valid_o = 0) and set err_o = 1 until reset.
REQ-018 SHALL make kill dominate: a kill cycle never pushes (REQ-008), so new requests after kill are live.
REQ-019 SHALL drive outstanding_o = count.

Reset
REQ-020 SHALL, on rst_ni low, asynchronously clear all stage registers, pointers, count, discard bits and err_o; all outputs 0.
REQ-021 SHALL, on reset mid-operation, abandon all outstanding entries; responses after reset with count = 0 set err_o.

Verification
REQ-022 REG_IN=1, DEPTH=4: iq_ready_i=1, next_addr_i=0x1000, icache_ready_i=1 -> icache_req_o=1, vaddr 0x1000 one cycle later; rvalid next cycle -> fetch_valid_o=1, fetch_vaddr_o=0x1000, count back to 0.
REQ-023 Fill: 4 accepted requests, no rvalid -> outstanding_o=4, icache_req_o=0; one rvalid -> count 3, icache_req_o=1 next cycle.
REQ-024 Kill: 3 outstanding, flush_i pulsed one cycle -> kill_s1/kill_s2 high one cycle (REG_IN=1: cycle after pulse), no push that cycle; next 3 rvalids give fetch_valid_o=0; 4th request (addr 0x2000) returns fetch_valid_o=1, vaddr 0x2000.
REQ-025 bp_valid_i=1 with rvalid in same stage cycle -> kill_s2_o=1, kill_s1_o=0, fetch_valid_o=0, entry popped.
REQ-026 Wrap and concurrency: 10 back-to-back push+pop cycles with DEPTH=2 -> count steady at 1, addresses returned in order, pointers wrap correctly.
REQ-027 rvalid with count=0 -> err_o=1 and held; rst_ni low mid-traffic -> all outputs 0 immediately, err_o cleared.
